// File: rtl/sync_frame_tx.sv
// rtl/sync_frame_tx.sv - bit-serial frame transmitter: sync header, MSB-first data, even parity, guard zeros
// Each register holds the value for the bit currently on the line, so the next-state logic also computes the next bit.
module sync_frame_tx #(
  parameter int         NBITS  = 8,
  parameter int         GUARD  = 2,
  parameter logic [3:0] HEADER = 4'b1011
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic             start,
  input  logic [NBITS-1:0] data_in,
  output logic             out_bit,
  output logic             busy,
  output logic             done,
  output logic [4:0]       bit_idx
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_PAR  = 3'd3;
  localparam logic [2:0] S_GRD  = 3'd4;

  localparam logic [4:0] HDR_LAST  = 5'd3;
  localparam logic [4:0] DATA_LAST = 5'(NBITS - 1);
  localparam logic [4:0] GRD_LAST  = 5'(GUARD - 1);

  logic [2:0]       state_q, state_d;
  logic [4:0]       idx_q, idx_d;
  logic [NBITS-1:0] sh_q, sh_d;
  logic             par_q, par_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       hdr_pos;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    par_d   = par_q;
    out_d   = 1'b0;
    done_d  = 1'b0;
    hdr_pos = 2'd2 - idx_q[1:0];
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_HDR;
          idx_d   = '0;
          sh_d    = data_in;
          par_d   = 1'b0;
          out_d   = HEADER[3];
        end
      end
      S_HDR: begin
        if (idx_q == HDR_LAST) begin
          state_d = S_DATA;
          idx_d   = '0;
          out_d   = sh_q[NBITS-1];
          par_d   = par_q ^ sh_q[NBITS-1];
          sh_d    = {sh_q[NBITS-2:0], 1'b0};
        end else begin
          idx_d = idx_q + 5'd1;
          out_d = HEADER[hdr_pos];
        end
      end
      S_DATA: begin
        if (idx_q == DATA_LAST) begin
          // par_q already covers every data bit, the last one was folded in when it was launched
          state_d = S_PAR;
          idx_d   = '0;
          out_d   = par_q;
        end else begin
          idx_d = idx_q + 5'd1;
          out_d = sh_q[NBITS-1];
          par_d = par_q ^ sh_q[NBITS-1];
          sh_d  = {sh_q[NBITS-2:0], 1'b0};
        end
      end
      S_PAR: begin
        state_d = S_GRD;
        idx_d   = '0;
      end
      S_GRD: begin
        if (idx_q == GRD_LAST) begin
          state_d = S_IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_bit = out_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign bit_idx = idx_q;

endmodule

// File: tb/tb_sync_frame_tx.sv
// tb/tb_sync_frame_tx.sv - randomized scoreboard bench for sync_frame_tx
module tb_sync_frame_tx;

  localparam int NBITS     = 8;
  localparam int GUARD     = 2;
  localparam int FRAME_LEN = 5 + NBITS + GUARD;
  localparam int PERIOD    = FRAME_LEN + 1;

  logic             clk_2 = 1'b0;
  logic             reset;
  logic             start;
  logic [NBITS-1:0] data_in;
  logic             out_bit;
  logic             busy;
  logic             done;
  logic [4:0]       bit_idx;

  sync_frame_tx #(.NBITS(NBITS), .GUARD(GUARD), .HEADER(4'b1011)) dut (
    .clk_2   (clk_2),
    .reset   (reset),
    .start   (start),
    .data_in (data_in),
    .out_bit (out_bit),
    .busy    (busy),
    .done    (done),
    .bit_idx (bit_idx)
  );

  always #5 clk_2 = ~clk_2;

  int n_checks = 0;
  int n_pass   = 0;
  logic [FRAME_LEN-1:0] exp_q[$];
  int e;
  int next_free;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Frame built directly from the line format: header, data MSB-first, even parity, guard zeros
  function automatic logic [FRAME_LEN-1:0] frame_of(input logic [NBITS-1:0] d);
    logic par;
    par = ($countones(d) % 2) == 1;
    return {4'b1011, d, par, {GUARD{1'b0}}};
  endfunction

  function automatic logic [4:0] exp_idx(input int p);
    if (p < 4) return 5'(p);
    if (p < 4 + NBITS) return 5'(p - 4);
    if (p == 4 + NBITS) return 5'd0;
    return 5'(p - 5 - NBITS);
  endfunction

  // Driver: inputs change on the falling edge; acceptance is predicted from the driver's own frame timing
  task automatic drive(input logic s, input logic [NBITS-1:0] d);
    @(negedge clk_2);
    start   = s;
    data_in = d;
    @(posedge clk_2);
    if (s && e >= next_free) begin
      exp_q.push_back(frame_of(d));
      next_free = e + PERIOD;
    end
    e++;
  endtask

  task automatic send(input logic [NBITS-1:0] d);
    drive(1'b1, d);
    while (e < next_free) drive(1'b0, NBITS'($urandom));
  endtask

  initial begin : monitor
    int pos;
    logic [FRAME_LEN-1:0] cur;
    logic [FRAME_LEN-1:0] expf;
    pos = 0;
    cur = '0;
    forever begin
      @(negedge clk_2);
      if (!reset) begin
        pos = 0;
        cur = '0;
      end else if (busy) begin
        chk("done_low_while_busy", 64'(done), 64'd0);
        chk("bit_idx", 64'(bit_idx), 64'(exp_idx(pos)));
        cur = {cur[FRAME_LEN-2:0], out_bit};
        pos++;
      end else begin
        chk("idle_out_bit", 64'(out_bit), 64'd0);
        chk("idle_bit_idx", 64'(bit_idx), 64'd0);
        if (done) begin
          chk("frame_len", 64'(pos), 64'(FRAME_LEN));
          chk("frame_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            expf = exp_q.pop_front();
            chk("frame_bits", 64'(cur), 64'(expf));
          end
          pos = 0;
          cur = '0;
        end else if (pos != 0) begin
          chk("done_after_busy", 64'(done), 64'd1);
          pos = 0;
          cur = '0;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    logic [NBITS-1:0] d;
    int guard_cnt;
    reset = 1'b0;
    start = 1'b1;
    data_in = 8'hFF;
    e = 0;
    next_free = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_2);
      chk("rst_out_bit", 64'(out_bit), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_bit_idx", 64'(bit_idx), 64'd0);
    end
    @(negedge clk_2);
    reset = 1'b1;
    start = 1'b0;
    repeat (3) drive(1'b0, 8'hFF);

    send(8'hA5);
    send(8'h01);

    // Second request mid-frame must be dropped
    drive(1'b1, 8'h3C);
    repeat (5) drive(1'b0, NBITS'($urandom));
    drive(1'b1, 8'hFF);
    while (e < next_free) drive(1'b0, 8'hFF);

    repeat (48) drive(1'b1, 8'hC3);
    while (e < next_free) drive(1'b0, NBITS'($urandom));

    // Abort while data bit 3 is on the line
    d = NBITS'($urandom);
    drive(1'b1, d);
    repeat (7) drive(1'b0, NBITS'($urandom));
    @(negedge clk_2);
    chk("abort_pre_bit", 64'(out_bit), 64'(d[NBITS-4]));
    #2 reset = 1'b0;
    #1;
    chk("abort_out_bit", 64'(out_bit), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    void'(exp_q.pop_back());
    repeat (2) begin
      @(negedge clk_2);
      chk("abort_no_done", 64'(done), 64'd0);
    end
    @(negedge clk_2);
    reset = 1'b1;
    start = 1'b0;
    e = 0;
    next_free = 0;
    send(8'h5A);

    repeat (300) drive($urandom_range(0, 3) == 0, NBITS'($urandom));

    guard_cnt = 0;
    while ((exp_q.size() != 0 || e < next_free) && guard_cnt < 40) begin
      drive(1'b0, NBITS'($urandom));
      guard_cnt++;
    end
    drive(1'b0, '0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
